// File: rtl/adc_tdm_pattern_src_if.sv
// rtl/adc_tdm_pattern_src_if.sv - config write port and TDM sample stream bundle for adc_tdm_pattern_src
interface adc_tdm_pattern_src_if #(
   parameter int DATA_W = 14,
   parameter int CH_W   = 1
);
   logic              cfg_we;
   logic [2:0]        cfg_addr;
   logic [15:0]       cfg_wdata;
   logic [DATA_W-1:0] dout;
   logic [CH_W-1:0]   dout_ch;
   logic              dout_valid;
   logic              dout_last;
   logic              or_flag;

   modport master (
      input  cfg_we, cfg_addr, cfg_wdata,
      output dout, dout_ch, dout_valid, dout_last, or_flag
   );

   modport slave (
      output cfg_we, cfg_addr, cfg_wdata,
      input  dout, dout_ch, dout_valid, dout_last, or_flag
   );
endinterface

// File: rtl/adc_tdm_pattern_src.sv
// rtl/adc_tdm_pattern_src.sv - TDM multi-channel ADC test-pattern source
// Optional: ADC_PAT_TWOS_COMP_EN selects two's-complement output (MSB inverted).
module adc_tdm_pattern_src #(
   parameter int DATA_W   = 14,
   parameter int NUM_CH   = 2,
   parameter int RAMP_OFS = 64,
   localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pdwn,
   input  logic sync,
   adc_tdm_pattern_src_if.master bus
);

   localparam logic [DATA_W-1:0] MID     = {1'b1, {(DATA_W-1){1'b0}}};
   localparam logic [15:0]       CB_A16  = 16'h2AAA;
   localparam logic [15:0]       CB_B16  = 16'h1555;
   localparam logic [DATA_W-1:0] CB_A    = CB_A16[DATA_W-1:0];
   localparam logic [DATA_W-1:0] CB_B    = CB_B16[DATA_W-1:0];
   localparam logic [15:0]       LFSR_RST = 16'hACE1;
   localparam logic [CH_W-1:0]   LAST_CH = CH_W'(NUM_CH - 1);

   function automatic logic [DATA_W-1:0] ramp_init(input int c);
      return DATA_W'(c * RAMP_OFS);
   endfunction

   logic [2:0]        sh_mode, act_mode, nxt_mode;
   logic [DATA_W-1:0] sh_user, act_user, nxt_user;
   logic [DATA_W-1:0] sh_step, act_step, nxt_step;
   logic [DATA_W-1:0] sh_thresh, act_thresh, nxt_thresh;
   logic [CH_W-1:0]   ch;
   logic [15:0]       lfsr;
   logic              phase;
   logic [DATA_W-1:0] ramp [NUM_CH];
   logic [DATA_W-1:0] v;
   logic [DATA_W-1:0] fmt_v;
   logic              wrap;
   logic              fb;
   logic              cfg_unused;

   assign cfg_unused = &{1'b0, bus.cfg_wdata};
   assign wrap = (ch == LAST_CH);
   assign fb   = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

   // Shadow including this cycle's write; sync copies this merged view to active.
   always_comb begin
      nxt_mode   = sh_mode;
      nxt_user   = sh_user;
      nxt_step   = sh_step;
      nxt_thresh = sh_thresh;
      if (bus.cfg_we) begin
         case (bus.cfg_addr)
            3'd0:    nxt_mode   = bus.cfg_wdata[2:0];
            3'd1:    nxt_user   = bus.cfg_wdata[DATA_W-1:0];
            3'd2:    nxt_step   = bus.cfg_wdata[DATA_W-1:0];
            3'd3:    nxt_thresh = bus.cfg_wdata[DATA_W-1:0];
            default: ;
         endcase
      end
   end

   always_comb begin
      v = MID;
      case (act_mode)
         3'd1:    v = act_user;
         3'd2:    v = phase ? CB_B : CB_A;
         3'd3:    v = ramp[ch];
         3'd4:    v = lfsr[DATA_W-1:0];
         default: v = MID;
      endcase
   end

`ifdef ADC_PAT_TWOS_COMP_EN
   assign fmt_v = {~v[DATA_W-1], v[DATA_W-2:0]};
`else
   assign fmt_v = v;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_mode        <= '0;
         sh_user        <= '0;
         sh_step        <= DATA_W'(1);
         sh_thresh      <= '1;
         act_mode       <= '0;
         act_user       <= '0;
         act_step       <= DATA_W'(1);
         act_thresh     <= '1;
         ch             <= '0;
         lfsr           <= LFSR_RST;
         phase          <= 1'b0;
         for (int c = 0; c < NUM_CH; c++) ramp[c] <= ramp_init(c);
         bus.dout       <= '0;
         bus.dout_ch    <= '0;
         bus.dout_valid <= 1'b0;
         bus.dout_last  <= 1'b0;
         bus.or_flag    <= 1'b0;
      end else begin
         sh_mode   <= nxt_mode;
         sh_user   <= nxt_user;
         sh_step   <= nxt_step;
         sh_thresh <= nxt_thresh;
         if (sync) begin
            ch         <= '0;
            lfsr       <= LFSR_RST;
            phase      <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) ramp[c] <= ramp_init(c);
            act_mode   <= nxt_mode;
            act_user   <= nxt_user;
            act_step   <= nxt_step;
            act_thresh <= nxt_thresh;
            bus.dout       <= '0;
            bus.dout_ch    <= '0;
            bus.dout_valid <= 1'b0;
            bus.dout_last  <= 1'b0;
            bus.or_flag    <= 1'b0;
         end else if (pdwn) begin
            bus.dout       <= '0;
            bus.dout_ch    <= '0;
            bus.dout_valid <= 1'b0;
            bus.dout_last  <= 1'b0;
            bus.or_flag    <= 1'b0;
         end else begin
            bus.dout       <= fmt_v;
            bus.dout_ch    <= ch;
            bus.dout_valid <= 1'b1;
            bus.dout_last  <= wrap;
            bus.or_flag    <= (v >= act_thresh);
            if (act_mode == 3'd3) ramp[ch] <= ramp[ch] + act_step;
            if (act_mode == 3'd4) lfsr <= {lfsr[14:0], fb};
            // Frame boundary: a write landing this cycle stays in shadow until the next one.
            if (wrap) begin
               ch         <= '0;
               phase      <= ~phase;
               act_mode   <= sh_mode;
               act_user   <= sh_user;
               act_step   <= sh_step;
               act_thresh <= sh_thresh;
            end else begin
               ch <= ch + CH_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_adc_tdm_pattern_src.sv
// tb/tb_adc_tdm_pattern_src.sv - directed self-checking bench for adc_tdm_pattern_src
module tb_adc_tdm_pattern_src;

   logic clk = 1'b0;
   logic rst_n;
   logic pdwn2, sync2, pdwn4, sync4;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   adc_tdm_pattern_src_if #(.DATA_W(14), .CH_W(1)) b2 ();
   adc_tdm_pattern_src_if #(.DATA_W(16), .CH_W(2)) b4 ();

   adc_tdm_pattern_src #(.DATA_W(14), .NUM_CH(2), .RAMP_OFS(64)) u2 (
      .clk(clk), .rst_n(rst_n), .pdwn(pdwn2), .sync(sync2), .bus(b2.master)
   );

   adc_tdm_pattern_src #(.DATA_W(16), .NUM_CH(4), .RAMP_OFS(64)) u4 (
      .clk(clk), .rst_n(rst_n), .pdwn(pdwn4), .sync(sync4), .bus(b4.master)
   );

   function automatic logic [13:0] f14(input logic [13:0] x);
`ifdef ADC_PAT_TWOS_COMP_EN
      return x ^ 14'h2000;
`else
      return x;
`endif
   endfunction

   function automatic logic [15:0] f16(input logic [15:0] x);
`ifdef ADC_PAT_TWOS_COMP_EN
      return x ^ 16'h8000;
`else
      return x;
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr2(input logic [2:0] a, input logic [15:0] d);
      b2.cfg_we = 1'b1; b2.cfg_addr = a; b2.cfg_wdata = d;
   endtask

   task automatic wr4(input logic [2:0] a, input logic [15:0] d);
      b4.cfg_we = 1'b1; b4.cfg_addr = a; b4.cfg_wdata = d;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; pdwn2 = 0; sync2 = 0; pdwn4 = 0; sync4 = 0;
      b2.cfg_we = 0; b2.cfg_addr = 0; b2.cfg_wdata = 0;
      b4.cfg_we = 0; b4.cfg_addr = 0; b4.cfg_wdata = 0;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if ({b2.dout, b2.dout_ch, b2.dout_valid, b2.dout_last, b2.or_flag} !== 18'h0) begin
         n_bad++;
         $display("FAIL reset_u2: got %h expected 0", {b2.dout, b2.dout_ch, b2.dout_valid, b2.dout_last, b2.or_flag});
      end
      n_cmp++;
      if ({b4.dout, b4.dout_ch, b4.dout_valid, b4.dout_last, b4.or_flag} !== 21'h0) begin
         n_bad++;
         $display("FAIL reset_u4: got %h expected 0", {b4.dout, b4.dout_ch, b4.dout_valid, b4.dout_last, b4.or_flag});
      end
   endtask

   task automatic test_ramp_basic();
      logic [13:0] e [4] = '{14'd0, 14'd64, 14'd1, 14'd65};
      logic        ech;
      rst_n = 1'b1;
      wr2(3'd0, 16'd3);
      tick();
      b2.cfg_we = 0;
      for (int i = 0; i < 2; i++) begin
         if (i == 1) tick();
         ech = (i == 1);
         n_cmp++;
         if (b2.dout !== f14(14'h2000) || b2.dout_ch !== ech || b2.dout_valid !== 1'b1 || b2.dout_last !== ech) begin
            n_bad++;
            $display("FAIL midscale_%0d: got dout=%h ch=%b v=%b l=%b expected dout=%h ch=%b", i, b2.dout, b2.dout_ch, b2.dout_valid, b2.dout_last, f14(14'h2000), ech);
         end
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         ech = (i % 2 == 1);
         n_cmp++;
         if (b2.dout !== f14(e[i]) || b2.dout_ch !== ech || b2.dout_valid !== 1'b1 || b2.dout_last !== ech) begin
            n_bad++;
            $display("FAIL ramp_basic_%0d: got dout=%h ch=%b v=%b l=%b expected dout=%h ch=%b", i, b2.dout, b2.dout_ch, b2.dout_valid, b2.dout_last, f14(e[i]), ech);
         end
      end
   endtask

   task automatic test_ramp_wrap();
      logic [13:0] ev;
      wr2(3'd2, 16'h1000);
      tick();
      wr2(3'd3, 16'h3000);
      sync2 = 1'b1;
      tick();
      sync2 = 1'b0; b2.cfg_we = 0;
      n_cmp++;
      if (b2.dout_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL wrap_sync_gap: got valid=%b expected 0", b2.dout_valid);
      end
      for (int f = 0; f < 5; f++) begin
         tick();
         ev = 14'((f * 32'h1000) % 32'h4000);
         n_cmp++;
         if (b2.dout !== f14(ev) || b2.dout_ch !== 1'b0 || b2.or_flag !== (f == 3)) begin
            n_bad++;
            $display("FAIL ramp_wrap_f%0d: got dout=%h ch=%b or=%b expected dout=%h ch=0 or=%b", f, b2.dout, b2.dout_ch, b2.or_flag, f14(ev), (f == 3));
         end
         tick();
      end
   endtask

   task automatic test_pdwn();
      logic [13:0] e [3] = '{14'd64, 14'd1, 14'd65};
      wr2(3'd2, 16'd1);
      sync2 = 1'b1;
      tick();
      sync2 = 1'b0; b2.cfg_we = 0;
      tick();
      n_cmp++;
      if (b2.dout !== f14(14'd0) || b2.dout_ch !== 1'b0 || b2.dout_valid !== 1'b1) begin
         n_bad++;
         $display("FAIL pdwn_pre: got dout=%h ch=%b v=%b expected dout=%h ch=0 v=1", b2.dout, b2.dout_ch, b2.dout_valid, f14(14'd0));
      end
      pdwn2 = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_cmp++;
         if (b2.dout_valid !== 1'b0 || b2.dout !== 14'd0 || b2.dout_last !== 1'b0 || b2.or_flag !== 1'b0) begin
            n_bad++;
            $display("FAIL pdwn_idle_%0d: got dout=%h v=%b l=%b or=%b expected all 0", i, b2.dout, b2.dout_valid, b2.dout_last, b2.or_flag);
         end
      end
      pdwn2 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++;
         if (b2.dout !== f14(e[i]) || b2.dout_ch !== (i % 2 == 0) || b2.dout_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL pdwn_resume_%0d: got dout=%h ch=%b v=%b expected dout=%h ch=%b", i, b2.dout, b2.dout_ch, b2.dout_valid, f14(e[i]), (i % 2 == 0));
         end
      end
   endtask

   task automatic test_sync_cfg();
      logic [13:0] e [3] = '{14'd0, 14'd64, 14'd3};
      wr2(3'd2, 16'd3);
      sync2 = 1'b1;
      tick();
      sync2 = 1'b0; b2.cfg_we = 0;
      n_cmp++;
      if (b2.dout_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL sync_gap: got valid=%b expected 0", b2.dout_valid);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++;
         if (b2.dout !== f14(e[i]) || b2.dout_ch !== (i % 2 == 1) || b2.dout_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL sync_cfg_%0d: got dout=%h ch=%b expected dout=%h ch=%b", i, b2.dout, b2.dout_ch, f14(e[i]), (i % 2 == 1));
         end
      end
   endtask

   task automatic test_mode_mid_frame();
      logic [15:0] ev;
      wr4(3'd1, 16'h0ABC);
      sync4 = 1'b1;
      tick();
      sync4 = 1'b0;
      wr4(3'd0, 16'd1);
      for (int i = 0; i < 8; i++) begin
         tick();
         b4.cfg_we = 0;
         ev = (i < 4) ? 16'h8000 : 16'h0ABC;
         n_cmp++;
         if (b4.dout !== f16(ev) || b4.dout_ch !== 2'(i % 4) || b4.dout_last !== (i % 4 == 3) || b4.dout_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL mode_mid_frame_%0d: got dout=%h ch=%0d l=%b expected dout=%h ch=%0d l=%b", i, b4.dout, b4.dout_ch, b4.dout_last, f16(ev), i % 4, (i % 4 == 3));
         end
      end
   endtask

   task automatic test_checker();
      logic [15:0] ev;
      wr4(3'd0, 16'd2);
      sync4 = 1'b1;
      tick();
      sync4 = 1'b0; b4.cfg_we = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         ev = (i < 4) ? 16'h2AAA : 16'h1555;
         n_cmp++;
         if (b4.dout !== f16(ev) || b4.or_flag !== 1'b0) begin
            n_bad++;
            $display("FAIL checker_%0d: got dout=%h or=%b expected dout=%h or=0", i, b4.dout, b4.or_flag, f16(ev));
         end
      end
   endtask

   task automatic test_pn16();
      logic [15:0] e [4] = '{16'hACE1, 16'h59C3, 16'hB387, 16'h670F};
      wr4(3'd0, 16'd4);
      sync4 = 1'b1;
      tick();
      sync4 = 1'b0; b4.cfg_we = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_cmp++;
         if (b4.dout !== f16(e[i]) || b4.dout_ch !== 2'(i) || b4.or_flag !== 1'b0) begin
            n_bad++;
            $display("FAIL pn16_%0d: got dout=%h ch=%0d or=%b expected dout=%h ch=%0d or=0", i, b4.dout, b4.dout_ch, b4.or_flag, f16(e[i]), i);
         end
      end
   endtask

   task automatic test_async_reset();
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (b2.dout_valid !== 1'b0 || b2.dout !== 14'd0 || b4.dout_valid !== 1'b0 || b4.dout !== 16'd0) begin
         n_bad++;
         $display("FAIL async_reset: got v2=%b d2=%h v4=%b d4=%h expected all 0", b2.dout_valid, b2.dout, b4.dout_valid, b4.dout);
      end
      tick();
      rst_n = 1'b1;
      tick();
      n_cmp++;
      if (b2.dout !== f14(14'h2000) || b2.dout_ch !== 1'b0 || b2.dout_valid !== 1'b1) begin
         n_bad++;
         $display("FAIL post_reset: got dout=%h ch=%b v=%b expected dout=%h ch=0 v=1", b2.dout, b2.dout_ch, b2.dout_valid, f14(14'h2000));
      end
   endtask

   initial begin
      test_reset();
      test_ramp_basic();
      test_ramp_wrap();
      test_pdwn();
      test_sync_cfg();
      test_mode_mid_frame();
      test_checker();
      test_pn16();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/adc_tdm_pattern_src.md
Name: adc_tdm_pattern_src

Overview:
- Parametrised, synthesizable successor to the single-channel ADC sim model.
- Generates test-pattern samples for NUM_CH channels, time-division multiplexed onto one bus at one sample per clock.
- Pattern modes: midscale, user-fixed, checkerboard, per-channel ramp, PN16.
- Provides a register-write config port with frame-aligned shadowing, a sync restart, power-down, and a per-sample overrange flag.
- Feeds capture/DSP testbenches and on-chip loopback in place of a real converter.

Parameters:
- DATA_W, 14, sample width in bits (4..16).
- NUM_CH, 2, channel count (1..16).
- RAMP_OFS, 64, reset/sync offset between adjacent channels' ramp start values.
- CH_W, $clog2(NUM_CH) min 1, channel-index width (derived, not user-set).

Ports:
- clk  input  1  sample clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- pdwn  input  1  power-down; level, synchronous effect.
- sync  input  1  one-cycle pulse; restarts pattern state.
- cfg_we  input  1  config write strobe.
- cfg_addr  input  3  register address.
- cfg_wdata  input  16  write data.
- dout  output  DATA_W  sample.
- dout_ch  output  CH_W  channel index of dout.
- dout_valid  output  1  dout valid.
- dout_last  output  1  dout is channel NUM_CH-1.
- or_flag  output  1  overrange flag aligned with dout.

Behaviour:
- Reset (async, rst_n=0) clears these outputs to 0: dout, dout_ch, dout_valid, dout_last, or_flag.
- Reset values of the other registers:
  - Active and shadow regs: mode=0, user=0, step=1, thresh=all ones (DATA_W bits).
  - Channel counter=0; LFSR=16'hACE1.
  - ramp[c] = c*RAMP_OFS mod 2^DATA_W.
- Registers, written into shadow copies; unused addresses are ignored:
  - 0: mode[2:0]; 0=midscale 2^(DATA_W-1), 1=user, 2=checkerboard, 3=ramp, 4=PN16, 5..7 treated as 0.
  - 1: user[DATA_W-1:0].
  - 2: step[DATA_W-1:0].
  - 3: thresh[DATA_W-1:0].
- Shadow-to-active copy happens only on the cycle the channel counter wraps from NUM_CH-1 to 0, or on sync. A write in that same cycle lands in the shadow and is applied at the next boundary.
- Emission: when pdwn=0, each cycle emits the channel at counter ch.
  - Outputs are registered; latency is 1 clock from counter state to dout.
  - dout_ch=ch; dout_valid=1; dout_last=(ch==NUM_CH-1).
  - ch increments and wraps NUM_CH-1 -> 0.
- Pattern value v, computed in offset binary:
  - Checkerboard: alternates 0x2AAA/0x1555, truncated to DATA_W, toggled per frame; all channels in a frame share one value.
  - Ramp: v=ramp[ch]; then ramp[ch] += step, modulo 2^DATA_W with silent wrap.
  - PN16: Fibonacci LFSR, taps 16,14,13,11; v=lfsr[DATA_W-1:0]; the LFSR steps once per emitted sample.
- or_flag = (v >= thresh), evaluated before output formatting.
- pdwn=1:
  - dout_valid, dout_last and or_flag go 0 next cycle; dout goes 0.
  - Counter, ramps, LFSR and checkerboard phase hold.
  - Releasing pdwn resumes at the held ch.
- sync=1 (pdwn is ignored for this cycle):
  - Next state: ch=0; ramps back to reset values; LFSR=16'hACE1; checkerboard phase=0; shadow copied to active.
  - No sample is emitted in the sync cycle: dout_valid=0 next cycle.
- sync and cfg_we in the same cycle: the write is captured into the shadow first, then copied to active. The new value is effective for the first post-sync sample.
- Async reset mid-frame aborts the frame immediately; no partial-frame completion.

Optional Feature:
- ADC_PAT_TWOS_COMP_EN.
- Defined: dout = v with MSB inverted (two's-complement format); or_flag unaffected.
- Undefined: dout = v (offset binary). No format logic present.

Test Plan:
- Reset, NUM_CH=2, DATA_W=14, mode=3 via boundary, step=1 -> dout sequence ch0:0,ch1:64,ch0:1,ch1:65; dout_last high on ch1 samples; valid continuous.
- Ramp wrap: user sets step=0x1000, run 5 frames -> ch0 values 0,0x1000,0x2000,0x3000,0x0000; no X, or_flag=1 when thresh=0x3000 on the 0x3000 sample only.
- Mode write mid-frame (ch=0 cycle, NUM_CH=4) to user=0x0ABC -> remaining 3 samples keep old pattern; next frame all four = 0x0ABC.
- pdwn high 5 cycles at ch=1 -> dout_valid=0 and dout=0 for 5 cycles; after release first sample ch=1 with ramp value continuing (no skip).
- sync during ramp run with concurrent cfg_we addr2=3 -> one invalid cycle, then ch0=0, ch1=64, next ch0=3.
- PN16 mode, DATA_W=16 -> first four samples 0xACE1 then 3 LFSR successors matching a reference model; with ADC_PAT_TWOS_COMP_EN, first = 0x2CE1.
